// File: rtl/stage_1.sv
// ============================================================================
// stage_1 : instruction fetch stage (PC, imem req/gnt/rvalid, instruction FIFO)
// Optional STAGE_1_PERF_EN adds fetch/flush counters.  Rev 1.0
// ============================================================================
`default_nettype none

module stage_1 #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc,
    input  logic        i_inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
);

    localparam int              PTR_W   = $clog2(BUF_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               mem_req_q, mem_req_d;
    logic               discard_q, discard_d;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        buf_inst_q [BUF_DEPTH];
    logic [31:0]        buf_pc_q   [BUF_DEPTH];

    logic               w_push, w_pop;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [31:0]        w_target;
    logic               w_unused;

    assign w_target = {i_b_pc[31:2], 2'b00};
    assign w_unused = ^i_b_pc[1:0];

    assign inst_valid  = (count_q != '0);
    assign inst        = inst_valid ? buf_inst_q[rd_ptr_q] : 32'd0;
    assign pc          = inst_valid ? buf_pc_q[rd_ptr_q]   : 32'd0;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // A redirect voids any same-cycle pop and any same-cycle response.
    assign w_pop       = inst_valid & i_inst_ready & ~i_b_taken;
    assign w_push      = (state_q == ST_WAIT) & i_mem_rvalid & ~discard_q & ~i_b_taken;
    assign w_count_nxt = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        discard_d  = discard_q;
        if (i_b_taken) begin
            fetch_pc_d = w_target;
            if (state_q == ST_WAIT && !i_mem_rvalid) begin
                // Response still in flight: keep waiting and drop it on arrival.
                discard_d = 1'b1;
            end else begin
                state_d    = ST_REQ;
                mem_req_d  = 1'b1;
                mem_addr_d = w_target;
                discard_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q < DEPTH_C) begin
                        state_d    = ST_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                ST_REQ: begin
                    if (i_mem_gnt) begin
                        state_d    = ST_WAIT;
                        mem_req_d  = 1'b0;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                ST_WAIT: begin
                    if (i_mem_rvalid) begin
                        discard_d = 1'b0;
                        if (w_count_nxt < DEPTH_C) begin
                            state_d    = ST_REQ;
                            mem_req_d  = 1'b1;
                            mem_addr_d = fetch_pc_q;
                        end else begin
                            state_d   = ST_IDLE;
                            mem_req_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= 32'd0;
            mem_req_q  <= 1'b0;
            discard_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int k = 0; k < BUF_DEPTH; k++) begin
                buf_inst_q[k] <= 32'd0;
                buf_pc_q[k]   <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            discard_q  <= discard_d;
            if (i_b_taken) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                // mem_addr_q still holds the address of the outstanding request.
                if (w_push) begin
                    buf_inst_q[wr_ptr_q] <= i_mem_rdata;
                    buf_pc_q[wr_ptr_q]   <= mem_addr_q;
                    wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
                end
                if (w_pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= w_count_nxt;
            end
        end
    end

`ifdef STAGE_1_PERF_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (w_pop) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (i_b_taken) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign fetch_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage_1.sv
// ============================================================================
// tb_stage_1 : self-checking bench for stage_1 with a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stage_1;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, b_taken, inst_ready, mem_gnt, mem_rvalid;
    logic        inst_valid, mem_req;
    logic [31:0] b_pc, mem_rdata, inst, pc, mem_addr, fetch_cnt, flush_cnt;

    always #5 clk = ~clk;

    stage_1 #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_b_taken    (b_taken),
        .i_b_pc       (b_pc),
        .i_inst_ready (inst_ready),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .pc           (pc),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .fetch_cnt    (fetch_cnt),
        .flush_cnt    (flush_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: next PC decode should see, next address memory should grant.
    logic [31:0] exp_pop_pc, exp_issue_pc;
    int          exp_fetch, exp_flush;
    // Memory responder state: one outstanding request at most.
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          rv_max;
    bit          prev_hold;
    logic [31:0] prev_addr;
    int          pops;
    logic [31:0] last_pop_pc;
    bit          found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_pop_pc   = RST_PC;
        exp_issue_pc = RST_PC;
        exp_fetch    = 0;
        exp_flush    = 0;
        pend         = 1'b0;
        pend_wait    = 0;
        prev_hold    = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        b_taken    = 1'b0;
        b_pc       = 32'd0;
        inst_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        rst = 1'b0;
        model_clear();
    endtask

    // One clock: drive inputs, check current outputs against the model, advance.
    task automatic tick(input logic g, input logic rdy, input logic br, input logic [31:0] bpc);
        logic        rv, pop, grant;
        logic [31:0] gaddr;
        rv         = pend && (pend_wait == 0);
        mem_rvalid = rv;
        mem_rdata  = rv ? (pend_addr ^ KEY) : 32'($urandom);
        mem_gnt    = g;
        inst_ready = rdy;
        b_taken    = br;
        b_pc       = bpc;
        if (prev_hold) begin
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("addr_hold", mem_addr, prev_addr);
        end
        if (!inst_valid) begin
            chk("empty_inst", inst, 32'd0);
            chk("empty_pc", pc, 32'd0);
        end
        pop = inst_valid && rdy && !br;
        if (pop) begin
            chk("pop_pc", pc, exp_pop_pc);
            chk("pop_inst", inst, exp_pop_pc ^ KEY);
            last_pop_pc = pc;
            pops++;
            exp_pop_pc = exp_pop_pc + 32'd4;
            exp_fetch++;
        end
        grant = mem_req && g && !br;
        gaddr = mem_addr;
        if (grant) begin
            chk("issue_addr", mem_addr, exp_issue_pc);
            exp_issue_pc = exp_issue_pc + 32'd4;
        end
        if (br) begin
            exp_pop_pc   = bpc & ~32'd3;
            exp_issue_pc = bpc & ~32'd3;
            exp_flush++;
        end
        prev_hold = mem_req && !g && !br;
        prev_addr = mem_addr;
        @(posedge clk); #1;
        if (rv) pend = 1'b0;
        else if (pend && pend_wait > 0) pend_wait--;
        if (grant) begin
            pend      = 1'b1;
            pend_addr = gaddr;
            pend_wait = $urandom_range(rv_max, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rv_max      = 0;
        pops        = 0;
        last_pop_pc = 32'hFFFF_FFFF;
        do_reset();

        // Fast memory, decode stalled: buffer fills to two entries, then no requests.
        for (int i = 0; i < 10; i++) begin
            if (i == 1) begin
                chk("first_req", 32'(mem_req), 32'd1);
                chk("first_addr", mem_addr, RST_PC);
            end
            if (i == 3) chk("latency_valid", 32'(inst_valid), 32'd1);
            if (i >= 6) chk("full_no_req", 32'(mem_req), 32'd0);
            tick(1'b1, 1'b0, 1'b0, 32'd0);
        end
        chk("full_head_pc", pc, RST_PC);
        pops = 0;
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0, 32'd0);
        chk("drain_pops", 32'(pops >= 3), 32'd1);

        // Redirect while a response is still outstanding.
        rv_max = 3;
        found  = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pend && pend_wait > 0) found = 1'b1;
            else tick(1'b1, 1'b1, 1'b0, 32'd0);
        end
        chk("wait_found", 32'(found), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req) found = 1'b1;
            else tick(1'b1, 1'b1, 1'b0, 32'd0);
        end
        chk("redir_req_seen", 32'(found), 32'd1);
        chk("redir_addr", mem_addr, 32'h0000_0100);
        pops = 0;
        for (int i = 0; i < 40 && pops == 0; i++) tick(1'b1, 1'b1, 1'b0, 32'd0);
        chk("redir_first_pc", last_pop_pc, 32'h0000_0100);

        // Redirect coincident with a response and a pop.
        rv_max = 0;
        found  = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pend && pend_wait == 0 && inst_valid) found = 1'b1;
            else tick(1'b1, 1'b0, 1'b0, 32'd0);
        end
        chk("coinc_found", 32'(found), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_4446);
        chk("flush_empty", 32'(inst_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (mem_req) found = 1'b1;
            else tick(1'b0, 1'b1, 1'b0, 32'd0);
        end
        chk("flush_req_seen", 32'(found), 32'd1);
        chk("flush_addr", mem_addr, 32'h0000_4444);

        // Grant withheld for five cycles, redirect on the third.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req) found = 1'b1;
            else tick(1'b0, 1'b1, 1'b0, 32'd0);
        end
        chk("hold_req_seen", 32'(found), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, (i == 2), 32'h0000_2000);
            if (i == 2) begin
                chk("hold_redir_req", 32'(mem_req), 32'd1);
                chk("hold_redir_addr", mem_addr, 32'h0000_2000);
            end
        end

        // Randomized traffic against the model.
        rv_max = 3;
        for (int i = 0; i < 2000; i++) begin
            tick($urandom_range(99, 0) < 60, $urandom_range(99, 0) < 70,
                 $urandom_range(99, 0) < 3, 32'($urandom));
        end
`ifdef STAGE_1_PERF_EN
        chk("rand_fetch_cnt", fetch_cnt, 32'(exp_fetch));
        chk("rand_flush_cnt", flush_cnt, 32'(exp_flush));
`else
        chk("rand_fetch_cnt", fetch_cnt, 32'd0);
        chk("rand_flush_cnt", flush_cnt, 32'd0);
`endif

        // Reset mid-traffic; a stale response right after reset must be ignored.
        do_reset();
        pend      = 1'b1;
        pend_addr = 32'h0000_5550;
        pend_wait = 0;
        rv_max    = 0;
        tick(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 100 && exp_fetch < 6; i++) begin
            tick(1'b1, 1'b1, (exp_flush < 2) && (i % 3 == 2), 32'h0000_0300 + 32'(i * 16));
        end
        chk("six_pops", 32'(exp_fetch), 32'd6);
`ifdef STAGE_1_PERF_EN
        chk("perf_fetch_cnt", fetch_cnt, 32'd6);
        chk("perf_flush_cnt", flush_cnt, 32'd2);
`else
        chk("perf_fetch_cnt", fetch_cnt, 32'd0);
        chk("perf_flush_cnt", flush_cnt, 32'd0);
`endif
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stage_1.md
Name: stage_1

Overview:
Instruction fetch stage: owns the fetch PC, issues word fetches to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions with their PCs in a small FIFO. Feeds the decode stage (stage_2) via a valid/ready interface on inst/pc. Takes the branch redirect (b_taken/b_pc) produced by decode, flushes wrong-path work and restarts at the target.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
BUF_DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  reset, synchronous, active-high
i_b_taken  input  1  redirect pulse from decode
i_b_pc  input  32  redirect target; bits [1:0] ignored (forced 00)
i_inst_ready  input  1  decode accepts head entry this cycle
inst_valid  output  1  buffer head valid
inst  output  32  instruction at buffer head
pc  output  32  PC of instruction at buffer head
mem_req  output  1  fetch request to instruction memory (registered)
mem_addr  output  32  fetch address, word aligned (registered)
i_mem_gnt  input  1  memory accepts request this cycle
i_mem_rvalid  input  1  read data valid; >= 1 cycle after gnt
i_mem_rdata  input  32  instruction word
fetch_cnt  output  32  instructions delivered to decode (see Optional Feature)
flush_cnt  output  32  redirects taken (see Optional Feature)

Behaviour:
- Reset (i_rst=1 at edge): fetch_pc<=RESET_PC, FIFO empty, state IDLE, discard<=0, mem_req<=0, mem_addr<=0; inst_valid=0, inst=0, pc=0 (outputs zeroed whenever FIFO empty). Reset mid-transaction abandons it; a late rvalid after reset is ignored (state not WAIT).
- At most one outstanding request. FSM states IDLE, REQ, WAIT:
  - IDLE: if count < BUF_DEPTH -> REQ; mem_req<=1, mem_addr<=fetch_pc.
  - REQ: mem_req/mem_addr held stable until i_mem_gnt. On gnt -> WAIT, mem_req<=0, fetch_pc<=fetch_pc+4 (wraps mod 2^32).
  - WAIT: on i_mem_rvalid: if discard=0 push {i_mem_rdata, pc_of_request}; else drop word and clear discard. Next state REQ (with new mem_addr=fetch_pc) if slots remain after this cycle's push/pop, else IDLE.
- Push only in WAIT with rvalid; space is guaranteed because issue requires count < BUF_DEPTH and only one request is outstanding.
- Pop when inst_valid & i_inst_ready. Simultaneous push and pop: count unchanged.
- inst/pc/inst_valid driven from buffer head registers (no combinational path from memory inputs to decode outputs). Best-case fetch latency: req to inst_valid = gnt cycle + rvalid cycle + 1.
- Redirect (i_b_taken=1), highest priority over all same-cycle events:
  - FIFO flushed (count<=0); a same-cycle pop is void.
  - fetch_pc<=b_pc & ~3.
  - IDLE or REQ (granted or not): next state REQ, mem_req<=1, mem_addr<=b_pc & ~3; a same-cycle gnt is treated as not granted (request withdrawn).
  - WAIT: stay WAIT, discard<=1; a same-cycle rvalid is dropped, then -> REQ at the target the next cycle.
  - Repeated redirects before the response arrives: fetch_pc takes the latest target; discard stays 1; exactly one response is dropped.
- No misaligned-target trap: low bits silently cleared.

Optional Feature:
STAGE_1_PERF_EN. Defined: fetch_cnt increments on every pop, flush_cnt on every cycle with i_b_taken=1; both 32-bit, wrap, reset to 0. Undefined: counter logic absent; fetch_cnt and flush_cnt ports present, tied to 0.

Test Plan:
- Reset then memory with gnt same cycle, rvalid 1 cycle later, data=addr^32'hA5A5_0000; i_inst_ready=1 -> decode sees pc 0,4,8,... in order with matching inst; mem_addr first presented as 0.
- i_inst_ready=0 for 10 cycles, BUF_DEPTH=2 -> exactly 2 entries buffered (pc 0,4), mem_req stays 0 while full; ready=1 -> pc 0,4,8 delivered with none lost or duplicated.
- Redirect in WAIT (rdata 32'h0000_0013 outstanding for pc 8), i_b_pc=32'h0000_0103 -> that word dropped, next mem_addr=32'h100, first valid pc=32'h100.
- Redirect coincident with rvalid and with pop (2 entries buffered) -> FIFO empty next cycle, inst_valid=0, next request addr = target, response not pushed.
- gnt held low 5 cycles in REQ -> mem_req/mem_addr stable all 5 cycles; redirect on cycle 3 -> mem_addr switches to target next cycle, old address never granted.
- With STAGE_1_PERF_EN: 6 instructions popped, 2 redirects -> fetch_cnt=6, flush_cnt=2; i_rst=1 -> both 0. Without macro: both read 0 throughout.
